// File: rtl/cpu_pkg.sv
// Shared CPU types: word type, fetch FSM states and the fetch-queue entry layout.
package cpu_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  // Instructions are word aligned, so the low two address bits are always dropped.
  function automatic word_t align_pc(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs between memory and decode.
// A push and a pop in the same cycle are accepted even when the queue is full.
import cpu_pkg::*;

module fetch_queue #(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem [QDEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == CW'(QDEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_entry = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: the read side is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push && rst_n && !flush) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, reads the combinational instruction memory,
// queues fetched words and issues them to decode over valid/ready.
import cpu_pkg::*;

module instr_fetch_unit #(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        halted
);

  fetch_state_e state;
  fetch_state_e state_next;
  word_t        pc_q;
  word_t        pc_next;
  logic         push;
  logic         pop;
  logic         flush;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;

  assign mem_addr   = pc_q;
  assign inst_valid = !q_empty;
  assign inst_data  = rd_entry.instr;
  assign inst_pc    = rd_entry.pc;
  assign halted     = (state == HALTED);
  assign wr_entry   = '{pc: pc_q, instr: mem_data};

  // State and PC registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
    end
  end

  // Halt is level sensitive; a redirect never changes which state halt_req selects.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (halt_req)  state_next = HALTED;
      HALTED:  if (!halt_req) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Push/pop/redirect control: redirect flushes and suppresses both push and pop.
  always_comb begin
    flush   = redirect_valid;
    pop     = inst_valid && inst_ready && !redirect_valid;
    push    = (state == FETCH) && !redirect_valid && !halt_req && (!q_full || pop);
    pc_next = pc_q;
    if (redirect_valid) begin
      pc_next = align_pc(redirect_pc);
    end else if (push) begin
      pc_next = pc_q + INSTR_BYTES;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .full     (q_full),
    .empty    (q_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with a combinational memory model.
module tb_instr_fetch_unit;

  localparam int QDEPTH = 2;
  localparam int NVEC   = 30;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        halted;

  int pass_count;
  int check_count;

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [31:0] redir_pc;
    logic        halt;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        exp_halted;
  } vec_t;

  vec_t vecs [NVEC];

  // Memory contents: a known word at address 0, an address-derived pattern elsewhere.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return (a == 32'h0) ? 32'h003100B3 : (32'h5A5A_0013 ^ a);
  endfunction

  assign mem_data = instr_at(mem_addr);

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle away from the edge.
  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rp,
                               input logic h, input logic rdy);
    rst_n          = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    halt_req       = h;
    inst_ready     = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [31:0] eaddr, input logic eh);
    check32({tag, ".inst_valid"}, {31'b0, inst_valid}, {31'b0, ev});
    check32({tag, ".inst_pc"},    inst_pc,   ev ? epc : 32'h0);
    check32({tag, ".inst_data"},  inst_data, ev ? instr_at(epc) : 32'h0);
    check32({tag, ".mem_addr"},   mem_addr,  eaddr);
    check32({tag, ".halted"},     {31'b0, halted}, {31'b0, eh});
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;

    //           rst redir pc            halt rdy  valid pc            addr          halted
    vecs[0]  = '{0, 0, 32'h0,          0, 1,  0, 32'h0,          32'h0,          0};
    vecs[1]  = '{1, 0, 32'h0,          0, 1,  1, 32'h0,          32'h4,          0};
    vecs[2]  = '{1, 0, 32'h0,          0, 1,  1, 32'h4,          32'h8,          0};
    vecs[3]  = '{1, 0, 32'h0,          0, 1,  1, 32'h8,          32'hC,          0};
    vecs[4]  = '{1, 0, 32'h0,          0, 1,  1, 32'hC,          32'h10,         0};
    vecs[5]  = '{1, 0, 32'h0,          0, 0,  1, 32'hC,          32'h14,         0};
    vecs[6]  = '{1, 0, 32'h0,          0, 0,  1, 32'hC,          32'h14,         0};
    vecs[7]  = '{1, 0, 32'h0,          0, 0,  1, 32'hC,          32'h14,         0};
    vecs[8]  = '{1, 0, 32'h0,          0, 0,  1, 32'hC,          32'h14,         0};
    vecs[9]  = '{1, 0, 32'h0,          0, 0,  1, 32'hC,          32'h14,         0};
    vecs[10] = '{1, 0, 32'h0,          0, 1,  1, 32'h10,         32'h18,         0};
    vecs[11] = '{1, 0, 32'h0,          0, 1,  1, 32'h14,         32'h1C,         0};
    vecs[12] = '{1, 1, 32'h23,         0, 1,  0, 32'h0,          32'h20,         0};
    vecs[13] = '{1, 0, 32'h0,          0, 1,  1, 32'h20,         32'h24,         0};
    vecs[14] = '{1, 0, 32'h0,          0, 1,  1, 32'h24,         32'h28,         0};
    vecs[15] = '{1, 0, 32'h0,          1, 0,  1, 32'h24,         32'h28,         1};
    vecs[16] = '{1, 0, 32'h0,          1, 1,  0, 32'h0,          32'h28,         1};
    vecs[17] = '{1, 0, 32'h0,          1, 1,  0, 32'h0,          32'h28,         1};
    vecs[18] = '{1, 0, 32'h0,          0, 1,  0, 32'h0,          32'h28,         0};
    vecs[19] = '{1, 0, 32'h0,          0, 1,  1, 32'h28,         32'h2C,         0};
    vecs[20] = '{1, 1, 32'hFFFF_FFFC,  0, 1,  0, 32'h0,          32'hFFFF_FFFC,  0};
    vecs[21] = '{1, 0, 32'h0,          0, 1,  1, 32'hFFFF_FFFC,  32'h0,          0};
    vecs[22] = '{1, 0, 32'h0,          0, 1,  1, 32'h0,          32'h4,          0};
    vecs[23] = '{1, 0, 32'h0,          0, 1,  1, 32'h4,          32'h8,          0};
    vecs[24] = '{0, 1, 32'h100,        1, 1,  0, 32'h0,          32'h0,          0};
    vecs[25] = '{1, 0, 32'h0,          0, 1,  1, 32'h0,          32'h4,          0};
    vecs[26] = '{1, 0, 32'h0,          1, 1,  0, 32'h0,          32'h4,          1};
    vecs[27] = '{1, 1, 32'h41,         1, 1,  0, 32'h0,          32'h40,         1};
    vecs[28] = '{1, 1, 32'h82,         0, 1,  0, 32'h0,          32'h80,         0};
    vecs[29] = '{1, 0, 32'h0,          0, 1,  1, 32'h80,         32'h84,         0};

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].redir, vecs[i].redir_pc, vecs[i].halt, vecs[i].ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                  vecs[i].exp_addr, vecs[i].exp_halted);
    end

    // Stall straight out of reset: queue fills to QDEPTH and the address freezes at 4*QDEPTH.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall_rst", 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput($sformatf("stall%0d", i), 1'b1, 32'h0,
                  (i < QDEPTH) ? 32'(4 * i) : 32'(4 * QDEPTH), 1'b0);
    end

    // Release: every address issues exactly once and in order.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput($sformatf("drain%0d", k), 1'b1, 32'(4 * k), 32'(4 * (k + QDEPTH)), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch front end of the CPU. Owns the program counter, drives word addresses into the combinational instruction memory, captures the returned instruction words into a small queue, and hands them to decode over a valid/ready handshake. Supports branch/jump redirect with queue flush and a halt request.

## Interface

- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `QDEPTH`, 2: fetch-queue entries; power of two, ≥2.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mem_addr`  out  32  byte address to instruction memory; equals the PC register; memory returns `mem_data` combinationally in the same cycle.
- `mem_data`  in  32  instruction word at `mem_addr`.
- `redirect_valid`  in  1  load new PC and flush queue this cycle.
- `redirect_pc`  in  32  target address; bits [1:0] ignored (forced to 0).
- `halt_req`  in  1  stop fetching (level-sensitive).
- `inst_valid`  out  1  queue head holds a valid instruction.
- `inst_ready`  in  1  decode accepts head this cycle.
- `inst_data`  out  32  instruction at queue head.
- `inst_pc`  out  32  address the head instruction was fetched from.
- `halted`  out  1  high in HALTED state.

## Operation

- State machine (`fetch_state_e`): FETCH, HALTED. Reset → FETCH.
- Push: in FETCH, when `redirect_valid`=0, `halt_req`=0, and queue not full (or full with pop this cycle), write {PC, `mem_data`} to queue tail and PC ← PC + 4.
- Pop: `inst_valid && inst_ready` removes head.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Redirect (any state): queue emptied, PC ← {`redirect_pc`[31:2], 2'b00}, no push that cycle, pop that cycle discarded (handshake in that cycle is not a transfer). Redirect in HALTED also returns state to FETCH if `halt_req`=0; otherwise stays HALTED with new PC.
- Halt: FETCH with `halt_req`=1 → HALTED; no pushes; queue continues to drain to decode. HALTED → FETCH when `halt_req`=0. PC holds while halted.
- Full queue with no pop: no push, PC holds, `mem_addr` stable.
- Redirect has priority over halt, pop and push.

## Timing

- Reset values: `mem_addr`=RESET_PC, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `halted`=0, queue empty, state FETCH.
- Fetch-to-issue latency 1 cycle: word present on `mem_data` at edge N appears at `inst_data` with `inst_valid`=1 after edge N.
- First `inst_valid` is the cycle after the first edge with `rst_n`=1.
- Steady state with `inst_ready`=1: one instruction per cycle, no bubbles.
- After redirect at edge N: `inst_valid`=0 for the cycle after N; target instruction valid after edge N+1.
- `inst_data`/`inst_pc` held stable while `inst_valid && !inst_ready`.
- Reset mid-operation: queue flushed, all outputs to reset values at that edge regardless of other inputs.
- `halted` is registered; rises the cycle after the edge that sampled `halt_req`=1.

## Structure

- Shared package `cpu_pkg`: `word_t` (32-bit), `INSTR_BYTES`=4, `fetch_state_e`, `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`, `QDEPTH` entries, push/pop/flush, full/empty, count width $clog2(QDEPTH)+1; simultaneous push+pop when full is legal.
- Top holds PC register, FSM, and push/redirect control.

## Test plan

- Reset with memory[0]=32'h003100B3, `inst_ready`=1 → cycle after reset release `inst_valid`=1, `inst_data`=32'h003100B3, `inst_pc`=0; then pcs 4, 8, 12 on consecutive cycles.
- `inst_ready`=0 for 5 cycles → exactly QDEPTH entries queued, `mem_addr` frozen at 4·QDEPTH, head stable; release → in-order drain, no loss or duplication.
- Redirect to 32'h0000_0023 while queue full and pop asserted → queue flushed, `mem_addr`=32'h20 next cycle, one bubble, next issued `inst_pc`=32'h20.
- `halt_req` pulse 3 cycles → `halted` high, no new pushes, queued entries still issue, PC resumes from held value on release.
- Redirect to 32'hFFFF_FFFC → issued pcs FFFF_FFFC then 0000_0000.
- Assert `rst_n`=0 mid-stream with `redirect_valid`=1 → all outputs at reset values next cycle, `mem_addr`=RESET_PC.
